vnarrow_sched: RTL and testbench

VNARROW_SCHED -- requirements
Module: vnarrow_sched

---
 rtl/vnarrow_sched.sv | 168 ++++++++++++++++
 tb/tb_vnarrow_sched.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vnarrow_sched.sv
// Vector narrowing scheduler: fetches source words one at a time, issues each to the
// narrowing datapath and waits for all results. Optional feature: VNARROW_SCHED_TAIL_MASK_EN.
module vnarrow_sched #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned SEW_WIDTH  = 2,
   parameter int unsigned BE_WIDTH   = 8,
   parameter int unsigned OUT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [SEW_WIDTH-1:0]  cmd_sew,
   input  logic [CNT_WIDTH-1:0]  cmd_nwords,
   input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [BE_WIDTH-1:0]   cmd_tail_be,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  nar_valid,
   output logic [DATA_WIDTH-1:0] nar_vec,
   output logic [SEW_WIDTH-1:0]  nar_sew,
   output logic                  nar_turn,
   output logic [BE_WIDTH-1:0]   nar_be,
   output logic [ADDR_WIDTH-1:0] nar_addr,
   input  logic                  nar_ret_valid,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StIssue, StDrain, StDone} state_e;

   state_e                state_q;
   logic [SEW_WIDTH-1:0]  sew_q;
   logic [CNT_WIDTH-1:0]  nwords_q;
   logic [ADDR_WIDTH-1:0] src_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [CNT_WIDTH-1:0]  idx_q;
   logic [CNT_WIDTH-1:0]  idx_inc;
   logic [CNT_WIDTH:0]    idx_ext;
   logic                  more_words;
   logic [OUT_WIDTH-1:0]  out_cnt_q;
   logic [OUT_WIDTH-1:0]  out_cnt_d;
   logic [BE_WIDTH-1:0]   be_sel;

   assign idx_inc    = idx_q + CNT_WIDTH'(1);
   assign idx_ext    = {1'b0, idx_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign more_words = idx_ext < {1'b0, nwords_q};

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

`ifdef VNARROW_SCHED_TAIL_MASK_EN
   logic [BE_WIDTH-1:0] tail_be_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tail_be_q <= '0;
      end else if (state_q == StIdle && cmd_valid) begin
         tail_be_q <= cmd_tail_be;
      end
   end

   assign be_sel = (idx_q == nwords_q - CNT_WIDTH'(1)) ? tail_be_q : '1;
`else
   logic unused_tail_be;

   assign unused_tail_be = ^cmd_tail_be;
   assign be_sel         = '1;
`endif

   // Issue and return in the same cycle cancel; stray returns at zero are dropped.
   always_comb begin
      out_cnt_d = out_cnt_q;
      if (nar_valid && !nar_ret_valid) begin
         if (out_cnt_q != '1) out_cnt_d = out_cnt_q + OUT_WIDTH'(1);
      end else if (!nar_valid && nar_ret_valid && out_cnt_q != '0) begin
         out_cnt_d = out_cnt_q - OUT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         sew_q     <= '0;
         nwords_q  <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         idx_q     <= '0;
         out_cnt_q <= '0;
         rd_req    <= 1'b0;
         rd_addr   <= '0;
         nar_valid <= 1'b0;
         nar_vec   <= '0;
         nar_sew   <= '0;
         nar_turn  <= 1'b0;
         nar_be    <= '0;
         nar_addr  <= '0;
         done      <= 1'b0;
      end else begin
         out_cnt_q <= out_cnt_d;
         // Pulsed outputs default low and are raised for the cycle of the state they belong to.
         rd_req    <= 1'b0;
         rd_addr   <= '0;
         nar_valid <= 1'b0;
         nar_vec   <= '0;
         nar_sew   <= '0;
         nar_turn  <= 1'b0;
         nar_be    <= '0;
         nar_addr  <= '0;
         done      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  sew_q    <= cmd_sew;
                  nwords_q <= cmd_nwords;
                  src_q    <= cmd_src_addr;
                  dst_q    <= cmd_dst_addr;
                  idx_q    <= '0;
                  if (cmd_nwords == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                     rd_req  <= 1'b1;
                     rd_addr <= cmd_src_addr;
                  end
               end
            end
            StFetch: state_q <= StWait;
            StWait: begin
               if (rd_valid) begin
                  state_q   <= StIssue;
                  nar_valid <= 1'b1;
                  nar_vec   <= rd_data;
                  nar_sew   <= sew_q;
                  nar_turn  <= idx_q[0];
                  nar_be    <= be_sel;
                  nar_addr  <= dst_q + ADDR_WIDTH'(idx_q >> 1);
               end
            end
            StIssue: begin
               idx_q <= idx_inc;
               if (more_words) begin
                  state_q <= StFetch;
                  rd_req  <= 1'b1;
                  rd_addr <= src_q + ADDR_WIDTH'(idx_inc);
               end else begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (out_cnt_q == '0 && !nar_ret_valid) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vnarrow_sched.sv
// Directed self-checking bench for vnarrow_sched; a background responder models the
// register file read port and the narrowing datapath return.
module tb_vnarrow_sched;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_sew;
   logic [7:0]  cmd_nwords;
   logic [31:0] cmd_src_addr;
   logic [31:0] cmd_dst_addr;
   logic [7:0]  cmd_tail_be;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_valid;
   logic [63:0] rd_data;
   logic        nar_valid;
   logic [63:0] nar_vec;
   logic [1:0]  nar_sew;
   logic        nar_turn;
   logic [7:0]  nar_be;
   logic [31:0] nar_addr;
   logic        nar_ret_valid;
   logic        busy;
   logic        done;

`ifdef VNARROW_SCHED_TAIL_MASK_EN
   localparam logic [7:0] ExpTail = 8'h0F;
`else
   localparam logic [7:0] ExpTail = 8'hFF;
`endif

   typedef struct {
      logic [63:0] vec;
      logic        turn;
      logic [31:0] addr;
      logic [7:0]  be;
      logic [1:0]  sew;
      int          cyc;
   } nar_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rd_delay = 1;
   int          ret_lat = 2;
   int          rd_wait = 0;
   bit          rd_pend = 0;
   logic [31:0] rd_pend_addr = '0;
   int          overlap = 0;
   int          both_cnt = 0;
   logic [31:0] rd_log[$];
   int          rd_cyc[$];
   nar_t        nar_log[$];
   int          ret_due[$];
   int          ret_log[$];
   int          done_cyc[$];

   vnarrow_sched dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_sew      (cmd_sew),
      .cmd_nwords   (cmd_nwords),
      .cmd_src_addr (cmd_src_addr),
      .cmd_dst_addr (cmd_dst_addr),
      .cmd_tail_be  (cmd_tail_be),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .nar_valid    (nar_valid),
      .nar_vec      (nar_vec),
      .nar_sew      (nar_sew),
      .nar_turn     (nar_turn),
      .nar_be       (nar_be),
      .nar_addr     (nar_addr),
      .nar_ret_valid(nar_ret_valid),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] data_of(input logic [31:0] a);
      return {32'hA5C3_0000, a};
   endfunction

   // Responder: drive this cycle's rd_valid / nar_ret_valid, then log DUT outputs.
   initial begin
      rd_valid      = 1'b0;
      rd_data       = '0;
      nar_ret_valid = 1'b0;
      forever begin
         @(negedge clk);
         nar_ret_valid = 1'b0;
         if (ret_due.size() > 0 && ret_due[0] == cyc) begin
            nar_ret_valid = 1'b1;
            void'(ret_due.pop_front());
            ret_log.push_back(cyc);
         end
         rd_valid = 1'b0;
         rd_data  = '0;
         if (rd_pend) begin
            if (rd_wait <= 1) begin
               rd_valid = 1'b1;
               rd_data  = data_of(rd_pend_addr);
               rd_pend  = 0;
            end else begin
               rd_wait--;
            end
         end
         if (rd_req) begin
            if (rd_pend) overlap++;
            rd_pend      = 1;
            rd_wait      = rd_delay;
            rd_pend_addr = rd_addr;
            rd_log.push_back(rd_addr);
            rd_cyc.push_back(cyc);
         end
         if (nar_valid) begin
            nar_log.push_back('{nar_vec, nar_turn, nar_addr, nar_be, nar_sew, cyc});
            ret_due.push_back(cyc + ret_lat);
            if (nar_ret_valid) both_cnt++;
         end
         if (done) done_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      rd_cyc.delete();
      nar_log.delete();
      ret_log.delete();
      done_cyc.delete();
      overlap  = 0;
      both_cnt = 0;
   endtask

   task automatic issue_cmd(input logic [1:0] sew, input logic [7:0] nw,
                            input logic [31:0] src, input logic [31:0] dst,
                            input logic [7:0] tbe, output int acc);
      cmd_sew      = sew;
      cmd_nwords   = nw;
      cmd_src_addr = src;
      cmd_dst_addr = dst;
      cmd_tail_be  = tbe;
      cmd_valid    = 1'b1;
      step();
      acc          = cyc;
      cmd_valid    = 1'b0;
      cmd_nwords   = '0;
      cmd_src_addr = '0;
      cmd_dst_addr = '0;
      cmd_tail_be  = '0;
      cmd_sew      = '0;
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      int n = 0;
      while ((busy || ret_due.size() != 0 || rd_pend) && n < max_cyc) begin
         step();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected idle", name, busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if ({rd_req, nar_valid, done, busy, nar_turn} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got req/nv/done/busy/turn=%b, expected 00000",
                  {rd_req, nar_valid, done, busy, nar_turn});
      end
      checks++;
      if ({rd_addr, nar_vec, nar_be, nar_addr, nar_sew} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rd_addr=%h vec=%h be=%h addr=%h sew=%h, expected 0",
                  rd_addr, nar_vec, nar_be, nar_addr, nar_sew);
      end
      rst = 1'b1;
      step();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b busy=%b, expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_basic();
      int acc;
      rd_delay = 1;
      ret_lat  = 2;
      clear_logs();
      issue_cmd(2'd1, 8'd4, 32'h10, 32'h40, 8'hFF, acc);
      wait_idle(80, "basic");
      checks++;
      if (rd_log.size() != 4 || nar_log.size() != 4) begin
         errors++;
         $display("FAIL basic_counts: got rd=%0d nar=%0d, expected 4 4",
                  rd_log.size(), nar_log.size());
      end
      for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
         checks++;
         if (rd_log[i] !== 32'h10 + i || rd_cyc[i] != acc + 3 * i) begin
            errors++;
            $display("FAIL basic_rd[%0d]: got addr=%h cyc=%0d, expected %h %0d",
                     i, rd_log[i], rd_cyc[i], 32'h10 + i, acc + 3 * i);
         end
      end
      for (int i = 0; i < 4 && i < nar_log.size(); i++) begin
         checks++;
         if (nar_log[i].turn !== i[0] || nar_log[i].addr !== 32'h40 + i / 2 ||
             nar_log[i].vec !== data_of(32'h10 + i) || nar_log[i].sew !== 2'd1 ||
             nar_log[i].be !== 8'hFF || nar_log[i].cyc != acc + 2 + 3 * i) begin
            errors++;
            $display("FAIL basic_nar[%0d]: got turn=%b addr=%h vec=%h sew=%0d be=%h cyc=%0d, expected %b %h %h 1 ff %0d",
                     i, nar_log[i].turn, nar_log[i].addr, nar_log[i].vec, nar_log[i].sew,
                     nar_log[i].be, nar_log[i].cyc, i[0], 32'h40 + i / 2,
                     data_of(32'h10 + i), acc + 2 + 3 * i);
         end
      end
      checks++;
      if (done_cyc.size() != 1 || ret_log.size() != 4) begin
         errors++;
         $display("FAIL basic_done_count: got done=%0d rets=%0d, expected 1 4",
                  done_cyc.size(), ret_log.size());
      end else if (done_cyc[0] != ret_log[3] + 2) begin
         errors++;
         $display("FAIL basic_done_time: got cycle %0d, expected %0d", done_cyc[0], ret_log[3] + 2);
      end
   endtask

   task automatic test_tail();
      int acc;
      logic [7:0] exp_be;
      rd_delay = 1;
      ret_lat  = 2;
      clear_logs();
      issue_cmd(2'd0, 8'd3, 32'h100, 32'h200, 8'h0F, acc);
      wait_idle(80, "tail");
      checks++;
      if (nar_log.size() != 3) begin
         errors++;
         $display("FAIL tail_count: got %0d issues, expected 3", nar_log.size());
      end
      for (int i = 0; i < 3 && i < nar_log.size(); i++) begin
         exp_be = (i == 2) ? ExpTail : 8'hFF;
         checks++;
         if (nar_log[i].be !== exp_be) begin
            errors++;
            $display("FAIL tail_be[%0d]: got %h, expected %h", i, nar_log[i].be, exp_be);
         end
      end
   endtask

   task automatic test_zero();
      int acc;
      clear_logs();
      issue_cmd(2'd2, 8'd0, 32'h55, 32'h66, 8'hFF, acc);
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_done_state: got done=%b ready=%b busy=%b, expected 1 0 1",
                  done, cmd_ready, busy);
      end
      step();
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: got done=%b ready=%b busy=%b, expected 0 1 0",
                  done, cmd_ready, busy);
      end
      wait_idle(20, "zero");
      checks++;
      if (rd_log.size() != 0 || nar_log.size() != 0 || done_cyc.size() != 1) begin
         errors++;
         $display("FAIL zero_counts: got rd=%0d nar=%0d done=%0d, expected 0 0 1",
                  rd_log.size(), nar_log.size(), done_cyc.size());
      end
   endtask

   task automatic test_rd_delay();
      int acc;
      rd_delay = 5;
      ret_lat  = 2;
      clear_logs();
      issue_cmd(2'd3, 8'd2, 32'h20, 32'h30, 8'hFF, acc);
      wait_idle(80, "rd_delay");
      checks++;
      if (overlap != 0 || rd_log.size() != 2 || nar_log.size() != 2) begin
         errors++;
         $display("FAIL delay_counts: got overlap=%0d rd=%0d nar=%0d, expected 0 2 2",
                  overlap, rd_log.size(), nar_log.size());
      end else begin
         checks++;
         if (nar_log[0].cyc != acc + 6 || rd_cyc[1] != acc + 7 || nar_log[1].cyc != acc + 13) begin
            errors++;
            $display("FAIL delay_timing: got nar0=%0d rd1=%0d nar1=%0d, expected %0d %0d %0d",
                     nar_log[0].cyc, rd_cyc[1], nar_log[1].cyc, acc + 6, acc + 7, acc + 13);
         end
         checks++;
         if (nar_log[1].vec !== data_of(32'h21) || nar_log[1].turn !== 1'b1) begin
            errors++;
            $display("FAIL delay_data: got vec=%h turn=%b, expected %h 1",
                     nar_log[1].vec, nar_log[1].turn, data_of(32'h21));
         end
      end
      rd_delay = 1;
   endtask

   task automatic test_same_cycle();
      int acc;
      rd_delay = 1;
      ret_lat  = 3;
      clear_logs();
      issue_cmd(2'd1, 8'd4, 32'h0, 32'h8, 8'hFF, acc);
      wait_idle(80, "same_cycle");
      checks++;
      if (both_cnt != 3) begin
         errors++;
         $display("FAIL same_overlap: got %0d coincident cycles, expected 3", both_cnt);
      end
      checks++;
      if (done_cyc.size() != 1 || ret_log.size() != 4) begin
         errors++;
         $display("FAIL same_done_count: got done=%0d rets=%0d, expected 1 4",
                  done_cyc.size(), ret_log.size());
      end else if (done_cyc[0] != ret_log[3] + 2) begin
         errors++;
         $display("FAIL same_done_time: got cycle %0d, expected %0d", done_cyc[0], ret_log[3] + 2);
      end
      ret_lat = 2;
   endtask

   task automatic test_reset_mid();
      int acc;
      rd_delay = 1;
      ret_lat  = 6;
      clear_logs();
      issue_cmd(2'd2, 8'd4, 32'h70, 32'h78, 8'hFF, acc);
      repeat (4) step();
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || nar_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_state: got busy=%b ready=%b done=%b nv=%b, expected 0 1 0 0",
                  busy, cmd_ready, done, nar_valid);
      end
      rst = 1'b1;
      wait_idle(30, "mid_reset");
      checks++;
      if (done_cyc.size() != 0 || nar_log.size() != 1) begin
         errors++;
         $display("FAIL mid_abandon: got done=%0d nar=%0d, expected 0 1",
                  done_cyc.size(), nar_log.size());
      end
      ret_lat = 2;
      clear_logs();
      issue_cmd(2'd0, 8'd2, 32'h80, 32'h90, 8'hFF, acc);
      wait_idle(60, "mid_rerun");
      checks++;
      if (rd_log.size() != 2 || nar_log.size() != 2 || done_cyc.size() != 1) begin
         errors++;
         $display("FAIL mid_rerun_counts: got rd=%0d nar=%0d done=%0d, expected 2 2 1",
                  rd_log.size(), nar_log.size(), done_cyc.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd_log[i] !== 32'h80 + i || nar_log[i].addr !== 32'h90 ||
                nar_log[i].turn !== i[0] || nar_log[i].vec !== data_of(32'h80 + i)) begin
               errors++;
               $display("FAIL mid_rerun[%0d]: got rd=%h addr=%h turn=%b vec=%h, expected %h 90 %b %h",
                        i, rd_log[i], nar_log[i].addr, nar_log[i].turn, nar_log[i].vec,
                        32'h80 + i, i[0], data_of(32'h80 + i));
            end
         end
      end
   endtask

   initial begin
      rst          = 1'b0;
      cmd_valid    = 1'b0;
      cmd_sew      = '0;
      cmd_nwords   = '0;
      cmd_src_addr = '0;
      cmd_dst_addr = '0;
      cmd_tail_be  = '0;
      test_reset();
      test_basic();
      test_tail();
      test_zero();
      test_rd_delay();
      test_same_cycle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule
